// File: rtl/axi_mem_responder.sv
// AXI4 memory-mapped responder backed by a word-addressed RAM.
// Independent write (AW/W/B) and read (AR/R) engines, each handling one burst at a time.
// Only FIXED and INCR bursts are serviced; anything unsupported or out of range answers SLVERR.
//
// write FSM
//   state  | meaning
//   W_INIT | leaving reset, awready still low
//   W_IDLE | awready=1, waiting for AW handshake
//   W_DATA | wready=1, accepting awlen+1 beats
//   W_RESP | bvalid=1, holding B until bready
// read FSM
//   state  | meaning
//   R_INIT | leaving reset, arready still low
//   R_IDLE | arready=1, waiting for AR handshake
//   R_DATA | rvalid=1, presenting beats until the rlast beat is taken
module axi_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int MW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // A beat is in error for unsupported burst/size or a word index past the RAM.
  function automatic logic beat_bad(input logic [ADDR_WIDTH-1:0] a,
                                    input logic [1:0] burst, input logic [2:0] size);
    beat_bad = burst[1] || (size != 3'(OFF)) || ((a >> OFF) >= ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] burst);
    next_addr = (burst == 2'b01) ? a + ADDR_WIDTH'(NB) : a;
  endfunction

  function automatic logic [MW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    word_idx = MW'(a >> OFF);
  endfunction

  // ---------------- write channel ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d, bresp_q, bresp_d;
  logic                  werr_q, werr_d;
  logic                  w_bad, mem_we;

  // Write FSM next state: latch AW, count beats, fold per-beat errors into the B response.
  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    w_bad     = beat_bad(waddr_q, wburst_q, wsize_q) || (wlast != (wcnt_q == wlen_q));
    case (w_state_q)
      W_INIT: w_state_d = W_IDLE;
      W_IDLE: begin
        if (awvalid) begin
          wid_d     = awid;
          waddr_d   = awaddr;
          wlen_d    = awlen;
          wsize_d   = awsize;
          wburst_d  = awburst;
          wcnt_d    = 8'd0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          mem_we  = !w_bad;
          wcnt_d  = wcnt_q + 8'd1;
          waddr_d = next_addr(waddr_q, wburst_q);
          werr_d  = werr_q | w_bad;
          if (wcnt_q == wlen_q) begin
            bresp_d   = (werr_q || w_bad) ? 2'b10 : 2'b00;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_INIT;
    endcase
  end

  // Write channel registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_INIT;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      bresp_q   <= bresp_d;
    end
  end

  // RAM byte-lane writes; no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) mem[word_idx(waddr_q)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign awready = (w_state_q == W_IDLE);
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bid     = wid_q;
  assign bresp   = bresp_q;

  // ---------------- read channel ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, ld_addr;
  logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]            rsize_q, rsize_d, ld_size;
  logic [1:0]            rburst_q, rburst_d, ld_burst, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rlast_q, rlast_d, ld, ld_last, ld_bad;

  // Read FSM next state: a beat is loaded on AR accept and on every non-final R accept,
  // so consecutive beats stream without bubbles. RAM is sampled before this edge's write.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    ld        = 1'b0;
    ld_addr   = next_addr(raddr_q, rburst_q);
    ld_burst  = rburst_q;
    ld_size   = rsize_q;
    ld_last   = ((rcnt_q + 8'd1) == rlen_q);
    case (r_state_q)
      R_INIT: r_state_d = R_IDLE;
      R_IDLE: begin
        if (arvalid) begin
          rid_d     = arid;
          rlen_d    = arlen;
          rsize_d   = arsize;
          rburst_d  = arburst;
          rcnt_d    = 8'd0;
          ld_addr   = araddr;
          ld_burst  = arburst;
          ld_size   = arsize;
          ld_last   = (arlen == 8'd0);
          ld        = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            rcnt_d = rcnt_q + 8'd1;
            ld     = 1'b1;
          end
        end
      end
      default: r_state_d = R_INIT;
    endcase
    ld_bad = beat_bad(ld_addr, ld_burst, ld_size);
    if (ld) begin
      raddr_d = ld_addr;
      rdata_d = ld_bad ? '0 : mem[word_idx(ld_addr)];
      rresp_d = ld_bad ? 2'b10 : 2'b00;
      rlast_d = ld_last;
    end
  end

  // Read channel registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_INIT;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_DATA);
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: scoreboard queues for B and R, a reference RAM model,
// inputs driven and outputs sampled on the falling clock edge.
module tb_axi_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = 3'd2, arsize = 3'd2;
  logic [1:0]  awburst = 2'b01, arburst = 2'b01, bresp, rresp;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
  logic        rlast, rvalid, rready = 1'b0;

  axi_mem_responder dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  r_exp_t      exp_r[$];
  logic [5:0]  exp_b[$];
  logic [31:0] model [1024];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          cyc      = 0;
  logic        r_toggle = 1'b0;
  logic        b_hold   = 1'b0;
  logic        r_stall_q = 1'b0;
  logic [38:0] r_prev = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_bad(input logic [31:0] a, input logic [1:0] burst);
    return burst[1] || ((a >> 2) >= 32'd1024);
  endfunction

  // Write burst: AW then nsend beats; the B expectation is queued only for a complete burst.
  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb,
                    input int wl_at, input int nsend);
    logic [31:0] a;
    logic        bad, anybad;
    int          t;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (!awready) chk("aw_timeout", 0, 1);
    @(negedge clk);
    awvalid = 1'b0;
    a = addr; anybad = 1'b0;
    for (int b = 0; b < nsend; b++) begin
      wdata = d0 + b; wstrb = strb; wlast = (b == wl_at); wvalid = 1'b1;
      bad = m_bad(a, burst) || (wlast != (b == int'(len)));
      if (!bad)
        for (int i = 0; i < 4; i++)
          if (strb[i]) model[int'(a >> 2)][8*i +: 8] = wdata[8*i +: 8];
      anybad |= bad;
      if (b == int'(len)) exp_b.push_back({id, anybad ? 2'b10 : 2'b00});
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      if (!wready) chk("w_timeout", 0, 1);
      @(negedge clk);
      if (burst == 2'b01) a = a + 32'd4;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  // Read burst: expected beats come from the RAM model at issue time.
  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst);
    logic [31:0] a;
    logic        bad;
    int          t;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      bad = m_bad(a, burst);
      exp_r.push_back('{id: id, data: bad ? 32'h0 : model[int'(a >> 2)],
                        resp: bad ? 2'b10 : 2'b00, last: (b == int'(len))});
      if (burst == 2'b01) a = a + 32'd4;
    end
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    if (!arready) chk("ar_timeout", 0, 1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && t < 300) begin @(negedge clk); t++; end
    if (exp_r.size() != 0 || exp_b.size() != 0) chk("drain_timeout", 0, 1);
  endtask

  // R monitor: drives rready, checks hold-while-stalled and each accepted beat.
  always @(negedge clk) begin
    r_exp_t e;
    cyc++;
    rready = r_toggle ? cyc[0] : 1'b1;
    if (r_stall_q) chk("r_stable", {rid, rdata, rresp, rlast}, r_prev);
    r_stall_q = rvalid && !rready;
    r_prev    = {rid, rdata, rresp, rlast};
    if (rvalid && rready) begin
      if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        e = exp_r.pop_front();
        chk("rdata", rdata, e.data);
        chk("rresp", rresp, e.resp);
        chk("rlast", rlast, e.last);
        chk("rid", rid, e.id);
      end
    end
  end

  // B monitor: drives bready and checks each accepted response.
  always @(negedge clk) begin
    logic [5:0] e;
    bready = !b_hold;
    if (bvalid && bready) begin
      if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        e = exp_b.pop_front();
        chk("bid", bid, e[5:2]);
        chk("bresp", bresp, e[1:0]);
      end
    end
  end

  initial begin
    int st, el;
    // reset with an AW request pending
    awvalid = 1'b1; awaddr = 32'h40; awlen = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid},
        '0);
    chk("rst_rdata", rdata, 32'h0);
    awvalid = 1'b0;
    rst = 1'b1;
    chk("rdy_before_edge", {awready, arready}, 2'b00);
    @(negedge clk);
    chk("rdy_after_edge", {awready, arready}, 2'b11);

    // INCR write then read back
    wr(4'd5, 32'h10, 8'd3, 2'b01, 32'hA0, 4'hF, 3, 4);
    drain();
    rd(4'd5, 32'h10, 8'd3, 2'b01);
    drain();

    // byte strobes
    wr(4'd1, 32'h0, 8'd0, 2'b01, 32'h11223344, 4'hF, 0, 1);
    wr(4'd1, 32'h0, 8'd0, 2'b01, 32'hAABBCCDD, 4'h5, 0, 1);
    drain();
    chk("model_strobe", model[0], 32'h11BB33DD);
    rd(4'd2, 32'h0, 8'd0, 2'b01);
    drain();

    // errors: out-of-range write (must not alias onto word 0), WRAP read, early wlast
    wr(4'd3, 32'd4096, 8'd0, 2'b01, 32'hDEADBEEF, 4'hF, 0, 1);
    drain();
    rd(4'd3, 32'h0, 8'd0, 2'b01);
    rd(4'd4, 32'h0, 8'd1, 2'b10);
    wr(4'd6, 32'h20, 8'd2, 2'b01, 32'h5550, 4'hF, 1, 3);
    drain();
    rd(4'd6, 32'h20, 8'd2, 2'b01);
    rd(4'd7, 32'd4092, 8'd1, 2'b01);
    drain();

    // FIXED burst: all beats land on one word
    wr(4'd8, 32'h200, 8'd3, 2'b00, 32'hC0, 4'hF, 3, 4);
    drain();
    rd(4'd8, 32'h200, 8'd1, 2'b00);
    drain();

    // read backpressure over 8 beats
    wr(4'd9, 32'h100, 8'd7, 2'b01, 32'h7700, 4'hF, 7, 8);
    drain();
    r_toggle = 1'b1;
    rd(4'd9, 32'h100, 8'd7, 2'b01);
    drain();
    r_toggle = 1'b0;

    // B backpressure: response held, no new AW accepted
    b_hold = 1'b1;
    wr(4'd10, 32'h180, 8'd0, 2'b01, 32'h99, 4'hF, 0, 1);
    for (int i = 0; i < 10; i++) begin
      chk("b_hold", {bvalid, awready, bid, bresp}, {1'b1, 1'b0, 4'd10, 2'b00});
      @(negedge clk);
    end
    b_hold = 1'b0;
    drain();

    // reset mid-burst: two beats committed, no B
    wr(4'd11, 32'h300, 8'd3, 2'b01, 32'hD0, 4'hF, 3, 4);
    drain();
    wr(4'd12, 32'h300, 8'd3, 2'b01, 32'hE0, 4'hF, 3, 2);
    rst = 1'b0;
    #1;
    chk("midrst_outs", {awready, wready, bvalid, arready, rvalid}, 5'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", {awready, arready, bvalid}, 3'b110);
    rd(4'd12, 32'h300, 8'd3, 2'b01);
    drain();

    // concurrent 16-beat write and read to disjoint regions
    wr(4'd13, 32'h500, 8'd15, 2'b01, 32'hC100, 4'hF, 15, 16);
    drain();
    st = cyc;
    fork
      wr(4'd1, 32'h400, 8'd15, 2'b01, 32'hB000, 4'hF, 15, 16);
      rd(4'd2, 32'h500, 8'd15, 2'b01);
    join
    drain();
    el = cyc - st;
    chk("conc_time", (el >= 16 && el <= 20), 1'b1);
    rd(4'd3, 32'h400, 8'd15, 2'b01);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
